// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared types and vector ordering for the truth-table sweep
//
// Purpose : state encoding, vector count and the step -> driven-minterm mapping.
// Macro   : SWEEP_GRAY_EN selects Gray-code drive order (default: binary order).
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK
  } state_e;

  localparam int NUM_VECTORS = 16;

  // Minterm driven at a given sweep step. Gray order changes one input per
  // step so the function block never sees a multi-input transition.
  function automatic logic [3:0] vec_of(input logic [3:0] step);
`ifdef SWEEP_GRAY_EN
    return step ^ (step >> 1);
`else
    return step;
`endif
  endfunction

endpackage

// File: rtl/lowest_set_idx16.sv
// rtl/lowest_set_idx16.sv - 16-to-4 priority encoder, lowest set bit wins
//
// Purpose : index of the lowest set bit of vec_i; 0 when vec_i is all zero.
// Ports   : vec_i [15:0] input vector
//           idx_o [3:0]  index of lowest set bit
module lowest_set_idx16 (
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o
);

  // Scan from the top down so the last hit, the lowest index, sticks.
  always_comb begin
    idx_o = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (vec_i[i]) idx_o = 4'(i);
    end
  end

endmodule

// File: rtl/truth_sweep_driver.sv
// rtl/truth_sweep_driver.sv - exhaustive 4-input stimulus, capture and compare
//
// Purpose : on start, drives all 16 minterms into an external combinational
//           function block, holds each for HOLD_CYCLES, samples f into a truth
//           table and compares it against EXPECTED.
// Macro   : SWEEP_GRAY_EN (see sweep_pkg) selects Gray drive order.
// Params  : HOLD_CYCLES  cycles per vector before sampling (>= 1)
//           EXPECTED     expected truth table, bit i = f(minterm i)
// Ports   : clk, rst_n      clock, async active-low reset
//           start          begin sweep (only honoured in IDLE)
//           f_in           function block output
//           abcd [3:0]     driven vector {A,B,C,D}
//           busy           sweep in progress (SETTLE/CHECK)
//           done           one-cycle result-valid pulse
//           table_out [15:0] captured truth table
//           pass           table_out == EXPECTED
//           mismatch_idx [3:0] lowest differing minterm, 0 on pass
module truth_sweep_driver
  import sweep_pkg::*;
#(
  parameter int          HOLD_CYCLES = 2,
  parameter logic [15:0] EXPECTED    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic        pass,
  output logic [3:0]  mismatch_idx
);

  localparam int              CW        = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [3:0]      LAST_STEP = 4'(NUM_VECTORS - 1);

  state_e        state_q;
  logic [3:0]    step_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    abcd_q;
  logic          busy_q;
  logic          done_q;
  logic [15:0]   table_q;
  logic          pass_q;
  logic [3:0]    mismatch_q;

  logic [3:0]    first_diff;

  lowest_set_idx16 u_first_diff (
    .vec_i (table_q ^ EXPECTED),
    .idx_o (first_diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_q     <= 4'd0;
      cnt_q      <= '0;
      abcd_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= 16'h0000;
      pass_q     <= 1'b0;
      mismatch_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= SETTLE;
            step_q     <= 4'd0;
            cnt_q      <= '0;
            table_q    <= 16'h0000;
            pass_q     <= 1'b0;
            mismatch_q <= 4'd0;
            abcd_q     <= vec_of(4'd0);
            busy_q     <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt_q == HOLD_LAST) begin
            // Capture by the driven minterm, so the table is order-independent.
            table_q[abcd_q] <= f_in;
            cnt_q           <= '0;
            if (step_q == LAST_STEP) begin
              state_q <= CHECK;
            end else begin
              step_q <= step_q + 4'd1;
              abcd_q <= vec_of(step_q + 4'd1);
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CHECK: begin
          pass_q     <= (table_q == EXPECTED);
          mismatch_q <= first_diff;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign abcd         = abcd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign pass         = pass_q;
  assign mismatch_idx = mismatch_q;

endmodule

// File: tb/tb_truth_sweep_driver.sv
// tb/tb_truth_sweep_driver.sv - self-checking bench for truth_sweep_driver
module tb_truth_sweep_driver;

  localparam int          H   = 2;
  localparam logic [15:0] EXP = 16'h6996;
  localparam int          LAT = 16 * H + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        f_in;
  logic [15:0] func_tt;
  logic [3:0]  abcd;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        pass;
  logic [3:0]  mismatch_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural function block: truth table lookup on the driven vector.
  assign f_in = func_tt[abcd];

  truth_sweep_driver #(
    .HOLD_CYCLES (H),
    .EXPECTED    (EXP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .f_in         (f_in),
    .abcd         (abcd),
    .busy         (busy),
    .done         (done),
    .table_out    (table_out),
    .pass         (pass),
    .mismatch_idx (mismatch_idx)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_vec(input int k);
`ifdef SWEEP_GRAY_EN
    return 4'(k ^ (k >> 1));
`else
    return 4'(k);
`endif
  endfunction

  function automatic logic [3:0] model_first_diff(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] d;
    d = a ^ b;
    for (int i = 0; i < 16; i++) if (d[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Follows the sweep after edge t0 until done, checking drive order and latency.
  task automatic wait_done(input string tag, input logic [15:0] tt);
    int n;
    int k;
    n = -1;
    for (int c = 1; c <= LAT + 8; c++) begin
      @(posedge clk); #1;
      if (done) begin
        n = c;
        break;
      end
      k = c / H;
      if (k > 15) k = 15;
      check({tag, "_abcd"}, {12'd0, abcd}, {12'd0, model_vec(k)});
    end
    check({tag, "_latency"}, 16'(n), 16'(LAT));
    check({tag, "_table"}, table_out, tt);
    check({tag, "_pass"}, {15'd0, pass}, {15'd0, (tt == EXP)});
    check({tag, "_idx"}, {12'd0, mismatch_idx}, {12'd0, model_first_diff(tt, EXP)});
    check({tag, "_busy_end"}, {15'd0, busy}, 16'd0);
  endtask

  task automatic run_sweep(input string tag, input logic [15:0] tt, input bit hold_start);
    @(negedge clk);
    func_tt = tt;
    start   = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    check({tag, "_abcd0"}, {12'd0, abcd}, {12'd0, model_vec(0)});
    check({tag, "_busy"}, {15'd0, busy}, 16'd1);
    wait_done(tag, tt);
  endtask

  initial begin
    int dones;
    logic [15:0] rnd;
    rst_n   = 1'b0;
    start   = 1'b0;
    func_tt = EXP;

    repeat (2) @(posedge clk);
    #1;
    check("rst_abcd", {12'd0, abcd}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_table", table_out, 16'd0);
    check("rst_pass", {15'd0, pass}, 16'd0);
    check("rst_idx", {12'd0, mismatch_idx}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Parity function matches the expected table.
    run_sweep("parity", EXP, 1'b0);
    // Single inverted minterm 5.
    run_sweep("inv5", EXP ^ 16'h0020, 1'b0);
    // Boundary mismatches at minterm 0 and minterm 15, and an all-zero table.
    run_sweep("inv0", EXP ^ 16'h0001, 1'b0);
    run_sweep("inv15", EXP ^ 16'h8000, 1'b0);
    run_sweep("zero", 16'h0000, 1'b0);

    // Randomized tables.
    for (int r = 0; r < 4; r++) begin
      rnd = 16'($urandom);
      run_sweep("rand", rnd, 1'b0);
    end

    // start held high: one done, then a fresh sweep on the next edge.
    run_sweep("hold1", EXP ^ 16'h0100, 1'b1);
    @(posedge clk); #1;
    check("hold_done_clr", {15'd0, done}, 16'd0);
    check("hold_restart_busy", {15'd0, busy}, 16'd1);
    check("hold_table_clr", table_out, 16'd0);
    check("hold_abcd0", {12'd0, abcd}, {12'd0, model_vec(0)});
    func_tt = EXP;
    start   = 1'b0;
    wait_done("hold2", EXP);
    dones = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("hold_no_retrigger", 16'(dones), 16'd0);

    // Reset at step 7 aborts the sweep immediately.
    @(negedge clk);
    func_tt = EXP;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7 * H) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_abcd", {12'd0, abcd}, 16'd0);
    check("abort_busy", {15'd0, busy}, 16'd0);
    check("abort_table", table_out, 16'd0);
    check("abort_pass", {15'd0, pass}, 16'd0);
    dones = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 5; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", 16'(dones), 16'd0);
    run_sweep("after_abort", EXP, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
